backdoor_bus_arbiter: RTL and testbench
=======================================

# backdoor_bus_arbiter

Sequencing and arbitration controller for the user-area register bus. Two masters share the bus: the backdoor SPI word port (requester 0) and the firmware bridge (requester 1). The block grants one requester at a time with round-robin fairness and drives a single strobe/ack bus cycle on its behalf. It returns the read data and a one-cycle completion pulse. It sits in the SYSCLK domain between the backdoor SPI / firmware bridge and the user-area address decoder.

## Interface
- ADDRESS_WIDTH, 7: register address width.
- DATA_WIDTH, 32: data word width.
- TIMEOUT_CYCLES, 255: watchdog limit in SYSCLK cycles; only used with BACKDOOR_ARB_TIMEOUT_EN.
- i_SYSCLK  in  1  system clock; all logic is on the rising edge.
- i_RST_N  in  1  asynchronous, active-low reset.
- i_REQ  in  2  per-requester level request; held high until that requester's o_ACK bit pulses.
- i_WE  in  2  per-requester write enable (1 = write, 0 = read).
- i_ADDR0, i_ADDR1  in  ADDRESS_WIDTH  per-requester address.
- i_WDATA0, i_WDATA1  in  DATA_WIDTH  per-requester write data.
- o_ACK  out  2  one-cycle completion pulse to the granted requester.
- o_RDATA  out  DATA_WIDTH  read data; valid in the o_ACK cycle, held until the next completion.
- o_GRANT  out  2  one-hot owner of the current bus cycle; 0 when idle.
- o_BUS_STB  out  1  bus cycle active.
- o_BUS_WE  out  1  bus write enable.
- o_BUS_ADDR  out  ADDRESS_WIDTH  bus address.
- o_BUS_WDATA  out  DATA_WIDTH  bus write data.
- i_BUS_ACK  in  1  slave completion; sampled only while o_BUS_STB = 1.
- i_BUS_RDATA  in  DATA_WIDTH  slave read data; sampled with i_BUS_ACK.
- o_TIMEOUT  out  1  sticky watchdog error flag (tied 0 when the feature is compiled out).

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any i_REQ bit is high, the arbiter picks the winner, and the winner's WE/ADDR/WDATA are registered onto the bus outputs. o_BUS_STB and o_GRANT are set. Next state is ACCESS.
- Round-robin arbitration:
  - A single request always wins.
  - On simultaneous requests, the requester not granted last wins.
  - The last-granted pointer updates on each grant. Its reset value is 1, so requester 0 wins the first tie.
- ACCESS: bus outputs are held stable. When i_BUS_ACK = 1:
  - capture i_BUS_RDATA into o_RDATA (for writes too);
  - drop o_BUS_STB;
  - pulse o_ACK[granted] for one cycle;
  - go to DONE.
- DONE: one cycle. o_GRANT is cleared. Requests are ignored this cycle, which gives the requester time to drop i_REQ. Next state is IDLE.
- A requester that keeps i_REQ high after DONE is treated as a new request. Fairness still applies.
- A request that drops before it is granted is ignored. A request that drops during ACCESS does not abort the bus cycle; the cycle still completes.
- Reset values: o_ACK 0, o_RDATA 0, o_GRANT 0, o_BUS_STB 0, o_BUS_WE 0, o_BUS_ADDR 0, o_BUS_WDATA 0, o_TIMEOUT 0, state IDLE.
- Reset asserted mid-cycle aborts the cycle immediately: STB drops asynchronously, and no o_ACK is issued.

## Timing
- i_REQ sampled high in IDLE at edge N: STB/GRANT are high after edge N.
- Slave acks in the first STB cycle (i_BUS_ACK sampled at edge N+1): o_ACK is high after edge N+1, and STB is low after N+1.
- Minimum request-to-ack latency is 2 cycles. Slave wait states add 1 cycle each.
- Back-to-back throughput: one bus cycle per 3 SYSCLK minimum (IDLE, ACCESS, DONE).
- i_BUS_ACK outside ACCESS is ignored.

## Configuration
- BACKDOOR_ARB_TIMEOUT_EN defined:
  - An 8-bit-or-wider cycle counter runs in ACCESS.
  - When the counter reaches TIMEOUT_CYCLES without i_BUS_ACK, the block ends the cycle as if acked, with o_RDATA = 32'hDEAD_BEEF. It sets o_TIMEOUT, then takes the normal DONE path.
  - o_TIMEOUT clears only on reset.
- BACKDOOR_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; o_TIMEOUT is constant 0.

## Structure
- Shared package backdoor_pkg holds:
  - the state encoding (IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2);
  - the timeout read pattern 32'hDEAD_BEEF;
  - the requester index constants REQ_SPI = 0 and REQ_FW = 1.
- One sub-module, backdoor_rr_arb: combinational 2-way round-robin grant from i_REQ and the last-grant pointer. The pointer register lives in the parent.

## Test plan
- Single write: REQ0, WE = 1, ADDR 7'h65, WDATA 32'h12345678, slave acks immediately.
  - Expect STB with those values 1 cycle after the request.
  - Expect o_ACK = 2'b01 2 cycles after the request; o_GRANT = 0 in DONE.
- Single read with wait states: REQ1, ADDR 7'h2A; slave acks after 3 wait cycles with 32'hF0F0F0F0.
  - Expect o_ACK = 2'b10 5 cycles after the request, with o_RDATA = 32'hF0F0F0F0.
- Simultaneous requests out of reset: both held high.
  - Expect grants in the order 0, 1, 0, 1 across 4 cycles; o_ACK never 2'b11.
- Reset mid-ACCESS: assert i_RST_N = 0 while STB is high.
  - Expect all outputs 0 immediately and no o_ACK.
  - After release, a new REQ0 completes normally.
- Request withdrawn before grant: REQ1 pulses for 1 cycle while requester 0 owns the bus.
  - Expect no grant to requester 1 after DONE.
- With BACKDOOR_ARB_TIMEOUT_EN: slave never acks.
  - Expect o_ACK after TIMEOUT_CYCLES, with o_RDATA = 32'hDEADBEEF and o_TIMEOUT = 1 (sticky).
  - Next cycle with a normal ack completes normally.

Source files
------------

// File: rtl/backdoor_pkg.sv
// backdoor_pkg: state encoding and shared constants for the backdoor bus arbiter.
package backdoor_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
  localparam int REQ_SPI = 0;
  localparam int REQ_FW = 1;
endpackage

// File: rtl/backdoor_rr_arb.sv
// backdoor_rr_arb: combinational 2-way round-robin grant; a tie goes to the requester not granted last.
module backdoor_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb grant = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/backdoor_bus_arbiter.sv
// backdoor_bus_arbiter: shares the user-area register bus between the SPI word port and the firmware bridge.
// Define BACKDOOR_ARB_TIMEOUT_EN to add an ACCESS watchdog that completes stuck cycles with TIMEOUT_RDATA.
module backdoor_bus_arbiter
  import backdoor_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     i_SYSCLK,
  input  logic                     i_RST_N,
  input  logic [1:0]               i_REQ,
  input  logic [1:0]               i_WE,
  input  logic [ADDRESS_WIDTH-1:0] i_ADDR0,
  input  logic [ADDRESS_WIDTH-1:0] i_ADDR1,
  input  logic [DATA_WIDTH-1:0]    i_WDATA0,
  input  logic [DATA_WIDTH-1:0]    i_WDATA1,
  output logic [1:0]               o_ACK,
  output logic [DATA_WIDTH-1:0]    o_RDATA,
  output logic [1:0]               o_GRANT,
  output logic                     o_BUS_STB,
  output logic                     o_BUS_WE,
  output logic [ADDRESS_WIDTH-1:0] o_BUS_ADDR,
  output logic [DATA_WIDTH-1:0]    o_BUS_WDATA,
  input  logic                     i_BUS_ACK,
  input  logic [DATA_WIDTH-1:0]    i_BUS_RDATA,
  output logic                     o_TIMEOUT
);
  state_t     state;
  logic       last;
  logic [1:0] win;
  logic       sel;
  logic       to_hit;

  backdoor_rr_arb u_arb (.req(i_REQ), .last(last), .grant(win));

  assign sel = win[REQ_FW];

`ifdef BACKDOOR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt;
  // cnt holds the number of ACCESS cycles already spent without an ack
  assign to_hit = cnt == CW'(TIMEOUT_CYCLES - 1) && !i_BUS_ACK;
  always_ff @(posedge i_SYSCLK or negedge i_RST_N)
    if (!i_RST_N) begin
      cnt       <= '0;
      o_TIMEOUT <= 1'b0;
    end else begin
      cnt <= state == ACCESS ? cnt + 1'b1 : '0;
      if (state == ACCESS && to_hit) o_TIMEOUT <= 1'b1;
    end
`else
  assign to_hit    = 1'b0;
  assign o_TIMEOUT = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
`endif

  always_ff @(posedge i_SYSCLK or negedge i_RST_N)
    if (!i_RST_N) begin
      state       <= IDLE;
      last        <= 1'b1;
      o_ACK       <= '0;
      o_RDATA     <= '0;
      o_GRANT     <= '0;
      o_BUS_STB   <= 1'b0;
      o_BUS_WE    <= 1'b0;
      o_BUS_ADDR  <= '0;
      o_BUS_WDATA <= '0;
    end else begin
      o_ACK <= '0;
      case (state)
        IDLE: if (|i_REQ) begin
          state       <= ACCESS;
          last        <= sel;
          o_GRANT     <= win;
          o_BUS_STB   <= 1'b1;
          o_BUS_WE    <= i_WE[sel ? REQ_FW : REQ_SPI];
          o_BUS_ADDR  <= sel ? i_ADDR1 : i_ADDR0;
          o_BUS_WDATA <= sel ? i_WDATA1 : i_WDATA0;
        end
        ACCESS: if (i_BUS_ACK || to_hit) begin
          state     <= DONE;
          o_ACK     <= o_GRANT;
          o_GRANT   <= '0;
          o_BUS_STB <= 1'b0;
          o_RDATA   <= i_BUS_ACK ? i_BUS_RDATA : DATA_WIDTH'(TIMEOUT_RDATA);
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_backdoor_bus_arbiter.sv
// tb_backdoor_bus_arbiter: directed and randomized checks against a transaction-level model of the arbiter.
module tb_backdoor_bus_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int TO = 12;
`ifdef BACKDOOR_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic          i_SYSCLK = 1'b0;
  logic          i_RST_N = 1'b0;
  logic [1:0]    i_REQ = '0;
  logic [1:0]    i_WE = '0;
  logic [AW-1:0] i_ADDR0 = '0, i_ADDR1 = '0;
  logic [DW-1:0] i_WDATA0 = '0, i_WDATA1 = '0, i_BUS_RDATA = '0;
  logic          i_BUS_ACK = 1'b0;
  logic [1:0]    o_ACK, o_GRANT;
  logic [DW-1:0] o_RDATA, o_BUS_WDATA;
  logic [AW-1:0] o_BUS_ADDR;
  logic          o_BUS_STB, o_BUS_WE, o_TIMEOUT;

  int checks = 0;
  int errors = 0;

  bit            m_busy, m_cool, m_to;
  int            m_owner, m_last, m_cyc;
  logic [1:0]    m_ack;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  backdoor_bus_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_SYSCLK(i_SYSCLK), .i_RST_N(i_RST_N), .i_REQ(i_REQ), .i_WE(i_WE),
    .i_ADDR0(i_ADDR0), .i_ADDR1(i_ADDR1), .i_WDATA0(i_WDATA0), .i_WDATA1(i_WDATA1),
    .o_ACK(o_ACK), .o_RDATA(o_RDATA), .o_GRANT(o_GRANT), .o_BUS_STB(o_BUS_STB),
    .o_BUS_WE(o_BUS_WE), .o_BUS_ADDR(o_BUS_ADDR), .o_BUS_WDATA(o_BUS_WDATA),
    .i_BUS_ACK(i_BUS_ACK), .i_BUS_RDATA(i_BUS_RDATA), .o_TIMEOUT(o_TIMEOUT)
  );

  always #5 i_SYSCLK = ~i_SYSCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy = 0; m_cool = 0; m_to = 0; m_owner = 0; m_last = 1; m_cyc = 0;
    m_ack = '0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
  endfunction

  // one bus transaction at a time, a one-cycle pause after each, ties broken away from the last owner
  function automatic void model_edge();
    m_ack = '0;
    if (m_cool) m_cool = 0;
    else if (m_busy) begin
      m_cyc++;
      if (i_BUS_ACK || (TIMEOUT_ON && m_cyc == TO)) begin
        m_ack   = 2'(1 << m_owner);
        m_rdata = i_BUS_ACK ? i_BUS_RDATA : 32'hDEADBEEF;
        m_to    = m_to | !i_BUS_ACK;
        m_busy  = 0;
        m_cool  = 1;
      end
    end else if (i_REQ != 2'b00) begin
      m_owner = (i_REQ == 2'b11) ? 1 - m_last : (i_REQ[1] ? 1 : 0);
      m_last  = m_owner;
      m_busy  = 1;
      m_cyc   = 0;
      m_we    = i_WE[m_owner];
      m_addr  = m_owner == 1 ? i_ADDR1 : i_ADDR0;
      m_wdata = m_owner == 1 ? i_WDATA1 : i_WDATA0;
    end
  endfunction

  task automatic compare();
    check("stb", o_BUS_STB, m_busy);
    check("grant", o_GRANT, m_busy ? 2'(1 << m_owner) : 2'b00);
    check("ack", o_ACK, m_ack);
    check("rdata", o_RDATA, m_rdata);
    check("timeout", o_TIMEOUT, m_to);
    check("bus_we", o_BUS_WE, m_we);
    check("bus_addr", o_BUS_ADDR, m_addr);
    check("bus_wdata", o_BUS_WDATA, m_wdata);
  endtask

  task automatic step();
    @(posedge i_SYSCLK);
    model_edge();
    #1;
    compare();
  endtask

  task automatic rand_drive();
    for (int i = 0; i < 2; i++) begin
      if (!i_REQ[i]) begin
        if ($urandom_range(2) == 0) begin
          i_REQ[i] = 1'b1;
          i_WE[i]  = 1'($urandom);
          if (i == 0) begin i_ADDR0 = AW'($urandom); i_WDATA0 = $urandom; end
          else begin i_ADDR1 = AW'($urandom); i_WDATA1 = $urandom; end
        end
      end else if ((m_ack[i] && $urandom_range(3) != 0) || $urandom_range(19) == 0) i_REQ[i] = 1'b0;
    end
    i_BUS_ACK   = $urandom_range(4) < 2;
    i_BUS_RDATA = $urandom;
  endtask

  task automatic do_reset();
    i_RST_N = 1'b0;
    i_REQ = '0; i_BUS_ACK = 1'b0;
    model_reset();
    repeat (2) @(posedge i_SYSCLK);
    #1;
    compare();
    i_RST_N = 1'b1;
  endtask

  logic [1:0] seq [4];
  int n;
  logic prev_stb;

  initial begin
    model_reset();
    do_reset();

    // single write, immediate slave ack
    i_REQ = 2'b01; i_WE = 2'b01; i_ADDR0 = 7'h65; i_WDATA0 = 32'h12345678;
    i_BUS_ACK = 1'b1; i_BUS_RDATA = '0;
    step();
    check("wr_stb", o_BUS_STB, 1'b1);
    check("wr_addr", o_BUS_ADDR, 7'h65);
    check("wr_wdata", o_BUS_WDATA, 32'h12345678);
    check("wr_we", o_BUS_WE, 1'b1);
    step();
    check("wr_ack", o_ACK, 2'b01);
    check("wr_grant_done", o_GRANT, 2'b00);
    i_REQ = '0; i_BUS_ACK = 1'b0;
    repeat (2) step();

    // read from requester 1 with three wait states
    i_REQ = 2'b10; i_WE = 2'b00; i_ADDR1 = 7'h2A; i_BUS_RDATA = 32'hF0F0F0F0;
    repeat (4) step();
    i_BUS_ACK = 1'b1;
    step();
    check("rd_ack", o_ACK, 2'b10);
    check("rd_data", o_RDATA, 32'hF0F0F0F0);
    i_REQ = '0; i_BUS_ACK = 1'b0;
    repeat (2) step();

    // simultaneous requests out of reset alternate 0,1,0,1
    do_reset();
    i_REQ = 2'b11; i_BUS_ACK = 1'b1;
    n = 0; prev_stb = 1'b0;
    repeat (12) begin
      step();
      if (o_BUS_STB && !prev_stb && n < 4) begin seq[n] = o_GRANT; n++; end
      prev_stb = o_BUS_STB;
    end
    check("tie_count", 64'(n), 64'd4);
    for (int i = 0; i < 4; i++) check("tie_order", seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    i_REQ = '0; i_BUS_ACK = 1'b0;
    repeat (2) step();

    // requester 1 pulses while requester 0 owns the bus
    i_REQ = 2'b01; step();
    i_REQ = 2'b11; step();
    i_REQ = 2'b01; step();
    i_BUS_ACK = 1'b1; step();
    i_REQ = '0; i_BUS_ACK = 1'b0;
    repeat (3) begin
      step();
      check("withdrawn_nogrant", o_GRANT, 2'b00);
    end

    // reset asserted in the middle of ACCESS
    i_REQ = 2'b01; step();
    i_RST_N = 1'b0;
    #1;
    check("rst_stb", o_BUS_STB, 1'b0);
    check("rst_grant", o_GRANT, 2'b00);
    check("rst_ack", o_ACK, 2'b00);
    do_reset();
    i_REQ = 2'b01; i_BUS_ACK = 1'b1; i_BUS_RDATA = 32'h0000_5A5A;
    repeat (2) step();
    check("post_rst_ack", o_ACK, 2'b01);
    i_REQ = '0; i_BUS_ACK = 1'b0;
    repeat (2) step();

`ifdef BACKDOOR_ARB_TIMEOUT_EN
    // slave never acks: watchdog completes the cycle
    i_REQ = 2'b10;
    repeat (TO + 1) step();
    check("to_ack", o_ACK, 2'b10);
    check("to_rdata", o_RDATA, 32'hDEADBEEF);
    check("to_flag", o_TIMEOUT, 1'b1);
    i_REQ = '0;
    repeat (2) step();
    i_REQ = 2'b01; i_BUS_ACK = 1'b1; i_BUS_RDATA = 32'h1234_ABCD;
    repeat (2) step();
    check("to_next_ack", o_ACK, 2'b01);
    check("to_next_rdata", o_RDATA, 32'h1234_ABCD);
    check("to_sticky", o_TIMEOUT, 1'b1);
    i_REQ = '0; i_BUS_ACK = 1'b0;
    repeat (2) step();
`endif

    repeat (3000) begin
      rand_drive();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
